dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory controller sitting at the far end of the MEM-stage address path. It accepts one load or store per handshake from the pipeline and drives an internal block RAM with registered address, enable and write-enable timing. Load data returns through a registered response channel, and `stall` tells the pipeline when a load is in flight. Out-of-range accesses are rejected with an error pulse and never touch the RAM.

## Interface
- `DEPTH_WORDS`, 4096: RAM depth in 32-bit words; power of two.
- `RD_LAT`, 1: BRAM read latency in cycles, counted from the enable cycle; legal values 1–2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address; word index = `req_addr[31:2]`.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables for stores; ignored for loads.
- `req_ready`  out  1  controller can accept a request.
- `rsp_valid`  out  1  one-cycle pulse: load data valid.
- `rsp_rdata`  out  32  load data; holds its last value between responses.
- `err`  out  1  one-cycle pulse: request rejected.
- `stall`  out  1  load in flight; equals `~req_ready` outside reset.

## Operation
- A request is accepted in any cycle where `req_valid && req_ready`.
- The FSM has three states:
  - `IDLE`: `req_ready` = 1.
  - `RD_WAIT`: `req_ready` = 0; an internal countdown runs `RD_LAT` + 1 cycles.
  - `RSP`: `rsp_valid` = 1, `req_ready` = 0; returns to `IDLE` next cycle.
- Store accepted in `IDLE`: the RAM port writes bytes `req_be` in the next cycle. The FSM stays in `IDLE`, so back-to-back stores run at one per cycle.
- Load accepted in `IDLE`: the FSM goes to `RD_WAIT`, then `RSP`.
- Range check: if `req_addr[31:2] >= DEPTH_WORDS`, the request is accepted but discarded.
  - No RAM enable is issued.
  - `err` pulses in the cycle after acceptance.
  - The FSM stays in `IDLE`. A rejected load produces no `rsp_valid`.
- A store with `req_be` = 0 is accepted and is a no-op. It produces no error.
- Order is preserved. A load accepted the cycle after a store sees the stored data, because port operations are serialised one per cycle.
- Reset values: `req_ready`, `rsp_valid`, `err` and `stall` are 0; `rsp_rdata` is 0; the state is `IDLE`.
  - `req_ready` rises in the first cycle after `rst` deasserts.
  - Reset during `RD_WAIT` or `RSP` aborts the load: no `rsp_valid` is produced. RAM contents are not cleared.

## Timing
- Take the accept cycle as T.
- The RAM enable, address and write-enable registers are active in cycle T+1.
- Load: `bram_rdata` is valid in T+1+`RD_LAT`. It is captured into `rsp_rdata` at the end of that cycle, and `rsp_valid` is high in T+2+`RD_LAT`.
  - Total load latency is `RD_LAT`+2 cycles.
  - The next request can be accepted at T+3+`RD_LAT`.
- Store: the write takes effect in T+1; `req_ready` stays high throughout.
- `err` is high in T+1 only.
- `req_valid` is sampled only when `req_ready` = 1. The requester holds the request while `req_ready` = 0.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A load with `req_addr[1:0]` ≠ 0 is rejected exactly like an out-of-range access: `err` pulse, no RAM access.
  - A store whose `req_be` is not one of 0001/0010/0100/1000/0011/1100/1111, shifted consistently with `req_addr[1:0]`, is also rejected.
- Not defined: `req_addr[1:0]` is ignored and `req_be` is applied as given.

## Structure
- Package `dmem_pkg` holds:
  - the FSM state enum (`IDLE`, `RD_WAIT`, `RSP`);
  - the default `DEPTH_WORDS` and `RD_LAT`;
  - a `word_idx_t` typedef sized `$clog2(DEPTH_WORDS)`;
  - the legal byte-enable patterns used by the alignment check.
- Sub-module `dmem_bram`: an inferred single-port RAM with 4 byte write enables and `RD_LAT` output register stages. It has no reset on its data path.

## Test plan
- Store then load: store 0xDEADBEEF to 0x0000_0010 with be = 1111, then load 0x10 → `rsp_valid` in T+3 (`RD_LAT`=1) with `rsp_rdata` = 0xDEADBEEF; `stall` is high for T+1..T+3.
- Byte-lane store: store 0x000000AA with be = 0001 over 0xDEADBEEF → load returns 0xDEADBEAA.
- Back-to-back: 4 stores in 4 consecutive cycles, then a load the next cycle → `req_ready` never drops during the stores, and the load returns the last value written.
- Out of range (`DEPTH_WORDS`=4096): load 0x0000_4000 → `err` high one cycle at T+1, no `rsp_valid`, `req_ready` stays 1, RAM unchanged.
- Reset mid-load: assert `rst` in T+1 of a load → no `rsp_valid`; after release, `req_ready` = 1 and earlier stored data is still readable.
- With `DMEM_ALIGN_CHECK_EN`: load 0x0000_0012 → `err` pulse, no response; with the macro undefined, the same load returns the word at 0x10.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory controller.
//   - state_e       : controller FSM states (IDLE, RD_WAIT, RSP)
//   - DEFAULT_*     : default RAM depth (words) and BRAM read latency
//   - word_idx_t    : word index sized for the default depth
//   - BE_PATTERNS   : legal store byte-enable shapes for the alignment check
//   - be_is_legal() : byte-enable legality against the address byte offset
package dmem_pkg;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 4096;
  localparam int unsigned DEFAULT_RD_LAT      = 1;

  typedef logic [$clog2(DEFAULT_DEPTH_WORDS)-1:0] word_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_e;

  localparam int unsigned NUM_BE_PAT = 7;
  localparam logic [3:0] BE_PATTERNS [NUM_BE_PAT] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  // A pattern is legal only when its lowest enabled lane sits at the byte
  // offset of the address. An all-zero enable is a legal no-op.
  function automatic logic be_is_legal(input logic [3:0] be, input logic [1:0] off);
    logic       ok;
    logic [3:0] below;
    below = 4'((5'd1 << off) - 5'd1);
    ok    = (be == 4'b0000);
    for (int i = 0; i < NUM_BE_PAT; i++) begin
      if ((be == BE_PATTERNS[i]) && be[off] && ((be & below) == 4'b0000)) begin
        ok = 1'b1;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// dmem_bram: inferred single-port block RAM, 32-bit words, 4 byte write enables.
// Read-first; the read word passes through RD_LAT output register stages, so
// data read in enable cycle E is visible on rdata in cycle E+RD_LAT.
// No reset on the data path.
//   clk   : clock
//   en    : port enable (read and/or write this cycle)
//   we    : per-byte write enables
//   addr  : word address
//   wdata : write data
//   rdata : read data after RD_LAT stages
module dmem_bram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem    [DEPTH_WORDS];
  logic [31:0] pipe_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      pipe_q[0] <= mem[addr];
    end
    for (int s = 1; s < RD_LAT; s++) begin
      pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign rdata = pipe_q[RD_LAT-1];

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the MEM stage.
// Accepts one load/store per req_valid&&req_ready handshake, registers the RAM
// enable/address/write-enable for the following cycle, and returns load data on
// a registered response channel. Out-of-range requests are accepted, dropped
// and flagged with a one-cycle err pulse.
// Optional feature: define DMEM_ALIGN_CHECK_EN to also reject misaligned loads
// and stores whose byte enables do not match the address offset.
//   clk, rst  : clock, synchronous active-high reset
//   req_*     : request channel (valid, we, byte addr, wdata, byte enables)
//   req_ready : request can be accepted this cycle
//   rsp_valid : one-cycle pulse with load data on rsp_rdata (held otherwise)
//   err       : one-cycle pulse, request rejected
//   stall     : load in flight
// RD_LAT legal range is 1..2.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned RD_LAT      = DEFAULT_RD_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic        stall
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        err_q, err_d;
  logic        stall_q, stall_d;
  logic        bram_en_q, bram_en_d;
  logic [3:0]  bram_we_q, bram_we_d;
  logic [AW-1:0] bram_addr_q, bram_addr_d;
  logic [31:0] bram_wdata_q, bram_wdata_d;
  logic [31:0] bram_rdata;

  logic [29:0] word_idx;
  logic        accept;
  logic        out_of_range;
  logic        misaligned;
  logic        reject;

  assign word_idx     = req_addr[31:2];
  assign accept       = req_valid && req_ready_q;
  assign out_of_range = ({2'b00, word_idx} >= DEPTH_WORDS);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = req_we ? !be_is_legal(req_be, req_addr[1:0])
                             : (req_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign misaligned      = 1'b0;
`endif

  assign reject = out_of_range || misaligned;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rsp_rdata_d  = rsp_rdata_q;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    err_d        = accept && reject;
    // A store with no byte enables never needs the port.
    bram_en_d    = accept && !reject && (!req_we || (req_be != 4'b0000));
    bram_we_d    = (accept && !reject && req_we) ? req_be : 4'b0000;

    if (accept) begin
      bram_addr_d  = word_idx[AW-1:0];
      bram_wdata_d = req_wdata;
    end

    unique case (state_q)
      IDLE: begin
        if (accept && !req_we && !reject) begin
          state_d = RD_WAIT;
          cnt_d   = 2'(RD_LAT);
        end
      end
      RD_WAIT: begin
        // cnt counts RD_LAT..0: enable cycle plus RD_LAT BRAM stages.
        if (cnt_q == 2'd0) begin
          state_d     = RSP;
          rsp_rdata_d = bram_rdata;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    stall_d     = !req_ready_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 4'b0000;
      bram_addr_q  <= '0;
      bram_wdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      err_q        <= err_d;
      stall_q      <= stall_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
    end
  end

  dmem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .RD_LAT      (RD_LAT)
  ) u_bram (
    .clk   (clk),
    .en    (bram_en_q),
    .we    (bram_we_q),
    .addr  (bram_addr_q),
    .wdata (bram_wdata_q),
    .rdata (bram_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err       = err_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed plus randomized bench for dmem_ctrl with a word-level
// memory model (associative array of words, byte-merge on store).
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = DEFAULT_DEPTH_WORDS;
  localparam int unsigned LAT   = DEFAULT_RD_LAT;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  logic        stall;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] model [int];

  dmem_ctrl #(
    .DEPTH_WORDS (DEPTH),
    .RD_LAT      (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .err       (err),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] be);
    int          idx;
    logic [31:0] cur;
    idx = int'(addr >> 2);
    cur = model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) cur[8*b +: 8] = data[8*b +: 8];
    end
    model[idx] = cur;
  endfunction

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input string tag);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data; req_be = be;
    tick();
    req_valid = 1'b0;
    check({tag, " err"}, 32'(err), 32'd0);
    model_store(addr, data, be);
  endtask

  task automatic do_load(input logic [31:0] addr, input string tag);
    logic [31:0] exp;
    int          lat;
    bit          got;
    exp = model[int'(addr >> 2)];
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_be = 4'($urandom_range(0, 15));
    req_wdata = $urandom;
    tick();
    req_valid = 1'b0;
    check({tag, " stall T+1"}, 32'(stall), 32'd1);
    check({tag, " ready T+1"}, 32'(req_ready), 32'd0);
    got = 1'b0;
    lat = 1;
    for (int i = 0; i < 8 && !got; i++) begin
      if (rsp_valid) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check({tag, " rsp seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(LAT + 2));
    check({tag, " rdata"}, rsp_rdata, exp);
    check({tag, " stall rsp"}, 32'(stall), 32'd1);
    tick();
    check({tag, " ready after"}, 32'(req_ready), 32'd1);
    check({tag, " rsp pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, " rdata held"}, rsp_rdata, exp);
  endtask

  task automatic do_reject(input logic [31:0] addr, input logic we, input logic [31:0] data,
                           input logic [3:0] be, input string tag);
    bit          seen;
    logic [31:0] held;
    held = rsp_rdata;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_be = be;
    tick();
    req_valid = 1'b0;
    check({tag, " err T+1"}, 32'(err), 32'd1);
    check({tag, " ready T+1"}, 32'(req_ready), 32'd1);
    tick();
    check({tag, " err T+2"}, 32'(err), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    check({tag, " no rsp"}, 32'(seen), 32'd0);
    check({tag, " rdata held"}, rsp_rdata, held);
  endtask

  initial begin
    bit          seen;
    logic [31:0] a;
    logic [3:0]  be;
    int          op;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    tick(); tick(); tick();
    check("reset ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    tick();
    check("post-reset ready", 32'(req_ready), 32'd1);
    check("post-reset stall", 32'(stall), 32'd0);

    // Store then load.
    do_store(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, "st1");
    do_load(32'h0000_0010, "ld1");

    // Byte-lane store and a zero-enable no-op store.
    do_store(32'h0000_0010, 32'h0000_00AA, 4'b0001, "st_byte");
    do_load(32'h0000_0010, "ld_byte");
    check("byte merge value", model[4], 32'hDEAD_BEAA);
    do_store(32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, "st_be0");
    do_load(32'h0000_0010, "ld_be0");

    // Back-to-back stores, then a load in the very next cycle.
    for (int i = 0; i < 4; i++) begin
      do_store(32'h0000_0020, 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'b1111, "b2b");
    end
    do_load(32'h0000_0020, "ld_b2b");

    // Out of range: word 4096 would alias word 0 if the index were truncated.
    do_store(32'h0000_0000, 32'h1122_3344, 4'b1111, "st_w0");
    do_reject(32'h0000_4000, 1'b0, 32'h0, 4'b0000, "oob_ld");
    do_reject(32'h0000_4000, 1'b1, 32'h5566_7788, 4'b1111, "oob_st");
    do_load(32'h0000_0000, "ld_w0");

    // Misaligned load.
`ifdef DMEM_ALIGN_CHECK_EN
    do_reject(32'h0000_0012, 1'b0, 32'h0, 4'b0000, "mis_ld");
    do_reject(32'h0000_0012, 1'b1, 32'h0, 4'b0011, "mis_st");
`else
    do_load(32'h0000_0012, "mis_ld");
`endif

    // Reset in T+1 of a load aborts it.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    check("rst-abort no rsp", 32'(seen), 32'd0);
    check("rst-abort ready", 32'(req_ready), 32'd1);
    do_load(32'h0000_0010, "ld_after_rst");

    // Randomized traffic over 16 words.
    for (int i = 0; i < 16; i++) begin
      do_store(32'h0000_0100 + 32'(i * 4), $urandom, 4'b1111, "rinit");
    end
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      a  = 32'h0000_0100 + 32'($urandom_range(0, 15) * 4);
`ifdef DMEM_ALIGN_CHECK_EN
      be = 4'b1111;
`else
      a  = a | 32'($urandom_range(0, 3));
      be = 4'($urandom_range(0, 15));
`endif
      if (op <= 3)      do_store(a, $urandom, be, "rnd_st");
      else if (op <= 7) do_load(a, "rnd_ld");
      else if (op == 8) do_reject(32'h0000_4000 + 32'($urandom_range(0, 1000) * 4), 1'($urandom),
                                  $urandom, 4'b1111, "rnd_oob");
      else              tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
